// File: rtl/br_pkg.sv
// Shared types and constants for the branch/jump resolution controller.
package br_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StEval,
    StRedir
  } br_state_e;

  typedef enum logic [1:0] {
    KindBranch = 2'd0,
    KindJal    = 2'd1,
    KindJalr   = 2'd2,
    KindRsvd   = 2'd3
  } br_kind_e;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [1:0] EXC_MISALIGNED = 2'd0;
  localparam logic [1:0] EXC_ILLEGAL    = 2'd2;

  typedef struct packed {
    logic illegal;
    logic taken;
  } br_cond_t;

  // Signedness is already applied by the comparator via funct3[1].
  function automatic br_cond_t br_cond(input logic [2:0] f3, input logic less,
                                       input logic equal);
    br_cond_t r;
    r.illegal = 1'b0;
    r.taken   = 1'b0;
    case (f3)
      F3_BEQ:            r.taken = equal;
      F3_BNE:            r.taken = ~equal;
      F3_BLT, F3_BLTU:   r.taken = less;
      F3_BGE, F3_BGEU:   r.taken = ~less;
      default:           r.illegal = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/br_target.sv
// Combinational control-flow target: pc+imm for branch/JAL, (rs1+imm) & ~1 for JALR.
module br_target
  import br_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  br_kind_e        kind_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] imm_i,
  input  logic [XLEN-1:0] rs1_i,
  output logic [XLEN-1:0] target_o
);

  logic [XLEN-1:0] base;

  always_comb begin
    base     = (kind_i == KindJalr) ? rs1_i : pc_i;
    target_o = base + imm_i;
    if (kind_i == KindJalr) begin
      target_o[0] = 1'b0;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Multi-cycle branch/jump resolution controller driving an external comparator.
// Optional BR_PERF_EN adds conditional-branch and taken-branch counters.
module branch_ctrl
  import br_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_kind_i,
  input  logic [2:0]       req_funct3_i,
  input  logic [XLEN-1:0]  req_pc_i,
  input  logic [XLEN-1:0]  req_imm_i,
  input  logic [XLEN-1:0]  req_rs1_i,
  input  logic [XLEN-1:0]  req_rs2_i,
  input  logic             flush_i,
  output logic [XLEN-1:0]  cmp_rs1_o,
  output logic [XLEN-1:0]  cmp_rs2_o,
  output logic             cmp_unsigned_o,
  input  logic             cmp_less_i,
  input  logic             cmp_equal_i,
  output logic             redir_valid_o,
  output logic [XLEN-1:0]  redir_pc_o,
  input  logic             redir_ready_i,
  output logic             done_valid_o,
  output logic             done_taken_o,
  output logic [XLEN-1:0]  done_link_o,
  output logic             exc_valid_o,
  output logic [1:0]       exc_cause_o
`ifdef BR_PERF_EN
  ,
  output logic [CNT_W-1:0] perf_branches_o,
  output logic [CNT_W-1:0] perf_taken_o
`endif
);

  br_state_e       state_q, state_d;
  br_kind_e        kind_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] pc_q, imm_q, rs1_q, rs2_q;
  logic [XLEN-1:0] redir_pc_q, redir_pc_d;
  logic [XLEN-1:0] link_q, link_d;
  logic            done_valid_q, done_valid_d;
  logic            done_taken_q, done_taken_d;
  logic            exc_valid_q, exc_valid_d;
  logic [1:0]      exc_cause_q, exc_cause_d;
  logic            capture;
  logic            illegal, taken;
  br_cond_t        cond;
  logic [XLEN-1:0] target;

  br_target #(
    .XLEN(XLEN)
  ) u_target (
    .kind_i  (kind_q),
    .pc_i    (pc_q),
    .imm_i   (imm_q),
    .rs1_i   (rs1_q),
    .target_o(target)
  );

  always_comb begin
    state_d      = state_q;
    capture      = 1'b0;
    redir_pc_d   = redir_pc_q;
    link_d       = link_q;
    done_valid_d = 1'b0;
    done_taken_d = done_taken_q;
    exc_valid_d  = 1'b0;
    exc_cause_d  = exc_cause_q;

    cond    = br_cond(f3_q, cmp_less_i, cmp_equal_i);
    illegal = (kind_q == KindRsvd) || ((kind_q == KindBranch) && cond.illegal);
    taken   = (kind_q != KindBranch) || cond.taken;

    case (state_q)
      StIdle: begin
        if (req_valid_i && !flush_i) begin
          capture = 1'b1;
          state_d = StEval;
        end
      end
      StEval: begin
        state_d = StIdle;
        if (!flush_i) begin
          link_d = pc_q + XLEN'(4);
          if (illegal) begin
            exc_valid_d = 1'b1;
            exc_cause_d = EXC_ILLEGAL;
          end else if (taken && (target[1:0] != 2'b00)) begin
            exc_valid_d = 1'b1;
            exc_cause_d = EXC_MISALIGNED;
          end else if (taken) begin
            redir_pc_d = target;
            state_d    = StRedir;
          end else begin
            done_valid_d = 1'b1;
            done_taken_d = 1'b0;
          end
        end
      end
      StRedir: begin
        // Flush wins over a same-cycle redirect handshake.
        if (flush_i) begin
          state_d = StIdle;
        end else if (redir_ready_i) begin
          done_valid_d = 1'b1;
          done_taken_d = 1'b1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      kind_q       <= KindBranch;
      f3_q         <= '0;
      pc_q         <= '0;
      imm_q        <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      redir_pc_q   <= '0;
      link_q       <= '0;
      done_valid_q <= 1'b0;
      done_taken_q <= 1'b0;
      exc_valid_q  <= 1'b0;
      exc_cause_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_pc_q   <= redir_pc_d;
      link_q       <= link_d;
      done_valid_q <= done_valid_d;
      done_taken_q <= done_taken_d;
      exc_valid_q  <= exc_valid_d;
      exc_cause_q  <= exc_cause_d;
      if (capture) begin
        kind_q <= br_kind_e'(req_kind_i);
        f3_q   <= req_funct3_i;
        pc_q   <= req_pc_i;
        imm_q  <= req_imm_i;
        rs1_q  <= req_rs1_i;
        rs2_q  <= req_rs2_i;
      end
    end
  end

  assign req_ready_o    = (state_q == StIdle);
  assign cmp_rs1_o      = rs1_q;
  assign cmp_rs2_o      = rs2_q;
  assign cmp_unsigned_o = f3_q[1];
  assign redir_valid_o  = (state_q == StRedir);
  assign redir_pc_o     = redir_pc_q;
  assign done_valid_o   = done_valid_q;
  assign done_taken_o   = done_taken_q;
  assign done_link_o    = link_q;
  assign exc_valid_o    = exc_valid_q;
  assign exc_cause_o    = exc_cause_q;

`ifdef BR_PERF_EN
  logic [CNT_W-1:0] perf_br_q, perf_tk_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_br_q <= '0;
      perf_tk_q <= '0;
    end else if (done_valid_d && (kind_q == KindBranch)) begin
      perf_br_q <= perf_br_q + CNT_W'(1);
      if (done_taken_d) begin
        perf_tk_q <= perf_tk_q + CNT_W'(1);
      end
    end
  end

  assign perf_branches_o = perf_br_q;
  assign perf_taken_o    = perf_tk_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Scoreboard bench for branch_ctrl: a driver queues expected events, a monitor checks them.
module tb_branch_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o;
  logic [1:0]  req_kind_i;
  logic [2:0]  req_funct3_i;
  logic [31:0] req_pc_i, req_imm_i, req_rs1_i, req_rs2_i;
  logic        flush_i;
  logic [31:0] cmp_rs1_o, cmp_rs2_o;
  logic        cmp_unsigned_o, cmp_less_i, cmp_equal_i;
  logic        redir_valid_o, redir_ready_i;
  logic [31:0] redir_pc_o;
  logic        done_valid_o, done_taken_o;
  logic [31:0] done_link_o;
  logic        exc_valid_o;
  logic [1:0]  exc_cause_o;
`ifdef BR_PERF_EN
  logic [31:0] perf_branches_o, perf_taken_o;
`endif

  branch_ctrl #(
    .XLEN (32),
    .CNT_W(32)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_kind_i     (req_kind_i),
    .req_funct3_i   (req_funct3_i),
    .req_pc_i       (req_pc_i),
    .req_imm_i      (req_imm_i),
    .req_rs1_i      (req_rs1_i),
    .req_rs2_i      (req_rs2_i),
    .flush_i        (flush_i),
    .cmp_rs1_o      (cmp_rs1_o),
    .cmp_rs2_o      (cmp_rs2_o),
    .cmp_unsigned_o (cmp_unsigned_o),
    .cmp_less_i     (cmp_less_i),
    .cmp_equal_i    (cmp_equal_i),
    .redir_valid_o  (redir_valid_o),
    .redir_pc_o     (redir_pc_o),
    .redir_ready_i  (redir_ready_i),
    .done_valid_o   (done_valid_o),
    .done_taken_o   (done_taken_o),
    .done_link_o    (done_link_o),
    .exc_valid_o    (exc_valid_o),
    .exc_cause_o    (exc_cause_o)
`ifdef BR_PERF_EN
    ,
    .perf_branches_o(perf_branches_o),
    .perf_taken_o   (perf_taken_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Stand-in for the external brcomp block.
  always_comb begin
    cmp_equal_i = (cmp_rs1_o == cmp_rs2_o);
    cmp_less_i  = cmp_unsigned_o ? (cmp_rs1_o < cmp_rs2_o)
                                 : ($signed(cmp_rs1_o) < $signed(cmp_rs2_o));
  end

  localparam int EvDone  = 0;
  localparam int EvExc   = 1;
  localparam int EvRedir = 2;
  localparam int ResNt   = 0;
  localparam int ResTk   = 1;
  localparam int ResExc  = 2;

  typedef struct {
    int          ev;
    logic [31:0] val;
    logic        taken;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic        redir_seen = 1'b0;
  logic [31:0] redir_hold = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input int ev, input logic [31:0] val, input logic taken);
    exp_t e;
    e.ev = ev; e.val = val; e.taken = taken;
    exp_q.push_back(e);
  endtask

  task automatic observe(input string name, input int ev, input logic [31:0] val,
                         input logic taken);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected actual ev=%0d val=%h taken=%b required none",
               name, ev, val, taken);
    end else begin
      e = exp_q.pop_front();
      if (e.ev != ev || e.val !== val || e.taken !== taken) begin
        errors++;
        $display("FAIL %s actual ev=%0d val=%h taken=%b required ev=%0d val=%h taken=%b",
                 name, ev, val, taken, e.ev, e.val, e.taken);
      end
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (redir_valid_o) begin
      if (!redir_seen) begin
        observe("redir", EvRedir, redir_pc_o, 1'b0);
        redir_seen = 1'b1;
        redir_hold = redir_pc_o;
      end else begin
        chk("redir_pc_stable", redir_pc_o, redir_hold);
      end
    end else begin
      redir_seen = 1'b0;
    end
    if (done_valid_o || exc_valid_o) begin
      chk("pulse_exclusive", {31'b0, done_valid_o & exc_valid_o}, 32'd0);
    end
    if (done_valid_o) observe("done", EvDone, done_link_o, done_taken_o);
    if (exc_valid_o) observe("exc", EvExc, {30'b0, exc_cause_o}, 1'b0);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic wait_redir();
    int n = 0;
    while (!redir_valid_o && n < 8) begin
      tick(1);
      n++;
    end
    if (!redir_valid_o) begin
      checks++;
      errors++;
      $display("FAIL redir_timeout actual=0 required=1");
    end
  endtask

  task automatic send(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                      input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2);
    req_kind_i   = kind;
    req_funct3_i = f3;
    req_pc_i     = pc;
    req_imm_i    = imm;
    req_rs1_i    = rs1;
    req_rs2_i    = rs2;
    req_valid_i  = 1'b1;
    tick(1);
    req_valid_i  = 1'b0;
  endtask

  // res selects the expected outcome; val is target (taken) or cause (exception).
  task automatic run(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] pc,
                     input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] rs2,
                     input int res, input logic [31:0] val, input logic [31:0] link,
                     input int stall);
    case (res)
      ResNt: push(EvDone, link, 1'b0);
      ResTk: begin
        push(EvRedir, val, 1'b0);
        push(EvDone, link, 1'b1);
      end
      default: push(EvExc, val, 1'b0);
    endcase
    send(kind, f3, pc, imm, rs1, rs2);
    if (res == ResTk) begin
      wait_redir();
      tick(stall);
      redir_ready_i = 1'b1;
      tick(1);
      redir_ready_i = 1'b0;
    end
    tick(2);
  endtask

  initial begin
    rst_i         = 1'b1;
    req_valid_i   = 1'b0;
    req_kind_i    = '0;
    req_funct3_i  = '0;
    req_pc_i      = '0;
    req_imm_i     = '0;
    req_rs1_i     = '0;
    req_rs2_i     = '0;
    flush_i       = 1'b0;
    redir_ready_i = 1'b0;
    tick(3);
    chk("rst_req_ready", {31'b0, req_ready_o}, 32'd1);
    chk("rst_valids", {29'b0, redir_valid_o, done_valid_o, exc_valid_o}, 32'd0);
    chk("rst_redir_pc", redir_pc_o, 32'd0);
    chk("rst_done_link", done_link_o, 32'd0);
    chk("rst_cmp_rs1", cmp_rs1_o, 32'd0);
    chk("rst_cmp_rs2", cmp_rs2_o, 32'd0);
    chk("rst_exc_cause", {30'b0, exc_cause_o}, 32'd0);
    rst_i = 1'b0;
    tick(1);

    // kind, f3, pc, imm, rs1, rs2, result, target/cause, link, stall
    run(2'd0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, ResTk, 32'h120, 32'h104, 0);  // BEQ
    run(2'd0, 3'b100, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, ResTk, 32'h210, 32'h204, 0);
    run(2'd0, 3'b110, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, ResNt, 32'h0, 32'h204, 0);
    run(2'd0, 3'b001, 32'h300, 32'h8, 32'd3, 32'd3, ResNt, 32'h0, 32'h304, 0);    // BNE
    run(2'd0, 3'b101, 32'h400, 32'hFFFF_FFF8, 32'd1, 32'hFFFF_FFFF, ResTk, 32'h3F8,
        32'h404, 2);                                                               // BGE
    run(2'd2, 3'b000, 32'h500, 32'h4, 32'h1001, 32'd0, ResTk, 32'h1004, 32'h504, 0);
    run(2'd1, 3'b000, 32'h100, 32'h6, 32'd0, 32'd0, ResExc, 32'd0, 32'h0, 0);      // JAL misal
    run(2'd0, 3'b010, 32'h100, 32'h20, 32'd0, 32'd0, ResExc, 32'd2, 32'h0, 0);
    run(2'd0, 3'b011, 32'h100, 32'h20, 32'd0, 32'd0, ResExc, 32'd2, 32'h0, 0);
    run(2'd3, 3'b000, 32'h100, 32'h20, 32'd0, 32'd0, ResExc, 32'd2, 32'h0, 0);
    run(2'd1, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'd0, 32'd0, ResTk, 32'h10,
        32'hFFFF_FFF4, 1);                                                         // wrap
    run(2'd0, 3'b001, 32'h100, 32'h2, 32'd1, 32'd2, ResExc, 32'd0, 32'h0, 0);      // taken misal
    run(2'd0, 3'b000, 32'h100, 32'h2, 32'd1, 32'd2, ResNt, 32'h0, 32'h104, 0);     // nt misal ok

    // Flush while idle blocks acceptance.
    req_kind_i  = 2'd1;
    req_pc_i    = 32'h100;
    req_imm_i   = 32'h20;
    req_valid_i = 1'b1;
    flush_i     = 1'b1;
    tick(1);
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    chk("flush_idle_ready", {31'b0, req_ready_o}, 32'd1);
    tick(3);

    // Flush during EVAL: nothing emitted.
    send(2'd0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
    chk("eval_busy", {31'b0, req_ready_o}, 32'd0);
    flush_i = 1'b1;
    tick(1);
    flush_i = 1'b0;
    chk("flush_eval_ready", {31'b0, req_ready_o}, 32'd1);
    tick(3);

    // Stalled redirect, then flush and redir_ready together.
    push(EvRedir, 32'h640, 1'b0);
    send(2'd0, 3'b111, 32'h600, 32'h40, 32'hFFFF_FFFF, 32'd1);
    wait_redir();
    tick(3);
    flush_i       = 1'b1;
    redir_ready_i = 1'b1;
    tick(1);
    flush_i       = 1'b0;
    redir_ready_i = 1'b0;
    chk("flush_redir_ready", {31'b0, req_ready_o}, 32'd1);
    chk("flush_redir_drop", {31'b0, redir_valid_o}, 32'd0);
    tick(3);

    // Reset in the middle of REDIR.
    push(EvRedir, 32'h120, 1'b0);
    send(2'd0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5);
    wait_redir();
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    #1;
    chk("rst_mid_redir_valid", {31'b0, redir_valid_o}, 32'd0);
    chk("rst_mid_ready", {31'b0, req_ready_o}, 32'd1);
    tick(1);
    rst_i = 1'b0;
    tick(1);

`ifdef BR_PERF_EN
    run(2'd0, 3'b000, 32'h100, 32'h20, 32'd5, 32'd5, ResTk, 32'h120, 32'h104, 0);
    run(2'd0, 3'b110, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, ResNt, 32'h0, 32'h204, 0);
    run(2'd0, 3'b100, 32'h200, 32'h10, 32'hFFFF_FFFF, 32'd1, ResTk, 32'h210, 32'h204, 0);
    run(2'd1, 3'b000, 32'h100, 32'h20, 32'd0, 32'd0, ResTk, 32'h120, 32'h104, 0);   // JAL
    run(2'd0, 3'b010, 32'h100, 32'h20, 32'd0, 32'd0, ResExc, 32'd2, 32'h0, 0);
    chk("perf_branches", perf_branches_o, 32'd3);
    chk("perf_taken", perf_taken_o, 32'd2);
`endif

    tick(2);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
